// File: rtl/smvm_stream_tx.sv
// Serializes one SMVM job (header, dense vector, CSR nonzeros, terminator) from a 1-cycle-latency job buffer.
// Optional content checking is enabled by defining SMVM_TX_CHECK_EN.
module smvm_stream_tx #(
  parameter int VAL_W  = 8,
  parameter int COL_W  = 3,
  parameter int NNZ_W  = 8,
  parameter int ADDR_W = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VAL_W-1:0]       rows,
  input  logic [COL_W:0]         cols,
  input  logic [NNZ_W-1:0]       nnz,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [COL_W+VAL_W:0]   mem_rdata,
  output logic                   tx_valid,
  output logic [VAL_W-1:0]       tx_val,
  output logic [COL_W-1:0]       tx_col,
  output logic                   tx_ipv,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_TERM} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_rd_cnt, w_rd_cnt_next;
  logic [COL_W:0]      r_cols;
  logic [NNZ_W-1:0]    r_nnz;
  logic                r_pend, r_pend_vec;
  logic                r_tx_valid, w_tx_valid_next;
  logic [VAL_W-1:0]    r_tx_val, w_tx_val_next;
  logic [COL_W-1:0]    r_tx_col, w_tx_col_next;
  logic                r_tx_ipv, w_tx_ipv_next;
  logic                r_done, w_done_next;
  logic                r_err, w_err_next;
  logic                w_start_ok, w_abort, w_term_err;
  logic [ADDR_W-1:0]   w_total;
  logic [VAL_W-1:0]    w_word_val;
  logic [COL_W-1:0]    w_word_col;
  logic                w_word_ipv;
`ifdef SMVM_TX_CHECK_EN
  logic [VAL_W-1:0]    r_rows;
  logic [NNZ_W-1:0]    r_ipv_cnt;
`endif

  assign w_start_ok = start & (rows != '0) & (cols != '0);
  assign w_total    = ADDR_W'(r_cols) + ADDR_W'(r_nnz);
  assign w_word_val = mem_rdata[VAL_W-1:0];
  assign w_word_col = mem_rdata[VAL_W +: COL_W];
  assign w_word_ipv = mem_rdata[VAL_W+COL_W];

`ifdef SMVM_TX_CHECK_EN
  // A zero-valued nonzero word cuts the job short; its slot carries the terminator.
  assign w_abort    = (r_state == S_STREAM) & r_pend & ~r_pend_vec & (w_word_val == '0);
  assign w_term_err = (32'(r_ipv_cnt) != 32'(r_rows));
`else
  assign w_abort    = 1'b0;
  assign w_term_err = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_rd_cnt_next   = r_rd_cnt;
    mem_rd          = 1'b0;
    mem_addr        = r_rd_cnt;
    w_tx_valid_next = 1'b0;
    w_tx_val_next   = '0;
    w_tx_col_next   = '0;
    w_tx_ipv_next   = 1'b0;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !rst) begin
          if (w_start_ok) begin
            mem_rd          = 1'b1;
            mem_addr        = '0;
            w_rd_cnt_next   = ADDR_W'(1);
            w_state_next    = S_STREAM;
            w_tx_valid_next = 1'b1;
            w_tx_val_next   = rows;
            w_tx_col_next   = COL_W'(cols - 1'b1);
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      S_STREAM: begin
        w_tx_valid_next = 1'b1;
        if (!w_abort && (r_rd_cnt < w_total)) begin
          mem_rd        = 1'b1;
          w_rd_cnt_next = r_rd_cnt + 1'b1;
        end
        if (w_abort) begin
          w_done_next  = 1'b1;
          w_err_next   = 1'b1;
          w_state_next = S_TERM;
        end else if (r_pend) begin
          w_tx_val_next = w_word_val;
          if (!r_pend_vec) begin
            w_tx_col_next = w_word_col;
            w_tx_ipv_next = w_word_ipv;
          end
        end else begin
          // All words have been delivered: this slot is the terminator.
          w_done_next  = 1'b1;
          w_err_next   = w_term_err;
          w_state_next = S_TERM;
        end
      end
      S_TERM:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_cnt   <= '0;
      r_cols     <= '0;
      r_nnz      <= '0;
      r_pend     <= 1'b0;
      r_pend_vec <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_val   <= '0;
      r_tx_col   <= '0;
      r_tx_ipv   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef SMVM_TX_CHECK_EN
      r_rows     <= '0;
      r_ipv_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_rd_cnt   <= w_rd_cnt_next;
      r_pend     <= mem_rd;
      r_pend_vec <= (r_state == S_IDLE) | (mem_addr < ADDR_W'(r_cols));
      r_tx_valid <= w_tx_valid_next;
      r_tx_val   <= w_tx_val_next;
      r_tx_col   <= w_tx_col_next;
      r_tx_ipv   <= w_tx_ipv_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      if (r_state == S_IDLE && w_start_ok) begin
        r_cols <= cols;
        r_nnz  <= nnz;
      end
`ifdef SMVM_TX_CHECK_EN
      if (r_state == S_IDLE && w_start_ok) begin
        r_rows    <= rows;
        r_ipv_cnt <= '0;
      end else if (r_state == S_STREAM && r_pend && !r_pend_vec && !w_abort && w_word_ipv) begin
        r_ipv_cnt <= r_ipv_cnt + 1'b1;
      end
`endif
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_val   = r_tx_val;
  assign tx_col   = r_tx_col;
  assign tx_ipv   = r_tx_ipv;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Directed and random jobs for smvm_stream_tx, checked beat-by-beat against a job-level reference model.
module tb_smvm_stream_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rows = '0;
  logic [3:0]  cols = '0;
  logic [7:0]  nnz = '0;
  logic        mem_rd;
  logic [8:0]  mem_addr;
  logic [11:0] mem_rdata = '0;
  logic        tx_valid, tx_ipv, busy, done, err;
  logic [7:0]  tx_val;
  logic [2:0]  tx_col;

  logic [11:0] mem [0:511];
  logic [8:0]  rd_q [$];
  logic [13:0] exp_q [$];
  int          exp_reads;
  int          errors = 0;
  int          checks = 0;

  smvm_stream_tx dut (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols), .nnz(nnz),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_val(tx_val), .tx_col(tx_col), .tx_ipv(tx_ipv),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_rd && !rst) rd_q.push_back(mem_addr);
  end

  // Observed output vector: {tx_valid, busy, tx_val, tx_col, tx_ipv, done, err}
  function automatic logic [15:0] obs();
    return {tx_valid, busy, tx_val, tx_col, tx_ipv, done, err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: the beat list of a job, written straight from the stream format.
  task automatic build_model(input int r, input int c, input int n);
    logic [11:0] w;
    logic [2:0]  hc;
    int          ipvs = 0;
    bit          ab = 0;
    hc = 3'(c - 1);
    exp_q.delete();
    exp_q.push_back({8'(r), hc, 3'b000});
    for (int i = 0; i < c; i++) begin
      w = mem[i];
      exp_q.push_back({w[7:0], 3'd0, 3'b000});
    end
    exp_reads = c + n;
    for (int j = 0; j < n; j++) begin
      w = mem[c + j];
`ifdef SMVM_TX_CHECK_EN
      if (w[7:0] == 8'd0) begin
        ab = 1;
        exp_reads = c + j + 1;
        break;
      end
`endif
      exp_q.push_back({w[7:0], w[10:8], w[11], 2'b00});
      ipvs += int'(w[11]);
    end
`ifdef SMVM_TX_CHECK_EN
    exp_q.push_back({11'd0, 1'b0, 1'b1, (ab || ipvs != r) ? 1'b1 : 1'b0});
`else
    exp_q.push_back({11'd0, 1'b0, 1'b1, ab});
`endif
  endtask

  // Starts a job at the current negedge; optionally pokes start at cycle poke or resets at cycle rst_at.
  task automatic run_job(input string tag, input int r, input int c, input int n,
                         input int poke, input int rst_at);
    bit ok;
    build_model(r, c, n);
    rd_q.delete();
    rows = 8'(r); cols = 4'(c); nnz = 8'(n); start = 1'b1;
    #1;
    check({tag, ".rd0"}, {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 9'd0});
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk);
      start = (k == poke);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check({tag, ".rst"}, {15'd0, mem_rd, obs()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      check($sformatf("%s.beat%0d", tag, k), {16'd0, obs()}, {16'd0, 2'b11, exp_q[k-1]});
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, ".idle"}, {16'd0, obs()}, 32'd0);
    check({tag, ".nreads"}, rd_q.size(), exp_reads);
    ok = 1;
    foreach (rd_q[i]) if (rd_q[i] != 9'(i)) ok = 0;
    check({tag, ".addrs"}, {31'd0, ok}, 32'd1);
    $display("job %s rows=%0d cols=%0d nnz=%0d beats=%0d reads=%0d", tag, r, c, n, exp_q.size(), rd_q.size());
  endtask

  task automatic bad_start(input string tag, input int r, input int c);
    rd_q.delete();
    rows = 8'(r); cols = 4'(c); nnz = 8'd3; start = 1'b1;
    #1;
    check({tag, ".nord"}, {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".err"}, {16'd0, obs()}, 32'd1);
    @(negedge clk);
    check({tag, ".quiet"}, {16'd0, obs()}, 32'd0);
    check({tag, ".nreads"}, rd_q.size(), 0);
    $display("bad start %s rows=%0d cols=%0d", tag, r, c);
  endtask

  task automatic fill_random(input int c, input int n);
    for (int i = 0; i < c + n; i++) begin
      mem[i] = 12'($urandom);
`ifdef SMVM_TX_CHECK_EN
      if (i >= c && $urandom_range(0, 7) != 0 && mem[i][7:0] == 8'd0) mem[i][7:0] = 8'd1;
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    #1;
    check("reset", {15'd0, mem_rd, obs()}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", {16'd0, obs()}, 32'd0);

    // Job 1 from the reference example; -1 = 8'hFF, -2 = 8'hFE.
    mem[0] = 12'h005; mem[1] = 12'h0FF; mem[2] = 12'h002;
    mem[3] = 12'h003; mem[4] = 12'hA04; mem[5] = 12'h9FE;
    run_job("ex1", 2, 3, 3, 0, 0);

    // Same job with a start poke mid-job, then restarted the cycle busy drops.
    run_job("poke", 2, 3, 3, 3, 0);
    run_job("b2b", 2, 3, 3, 0, 0);

    mem[0] = 12'h07F;
    run_job("min", 1, 1, 0, 0, 0);

    @(negedge clk);
    bad_start("cols0", 4, 0);
    bad_start("rows0", 0, 2);

    // Reset mid-job, then a replay from the header.
    mem[0] = 12'h005; mem[1] = 12'h0FF; mem[2] = 12'h002;
    mem[3] = 12'h003; mem[4] = 12'hA04; mem[5] = 12'h9FE;
    run_job("trunc", 2, 3, 3, 0, 4);
    run_job("replay", 2, 3, 3, 0, 0);

    // Largest vector, and a zero-valued nonzero passed through (or aborting when checked).
    fill_random(8, 4);
    mem[9][7:0] = 8'd0;
    run_job("zeroval", 255, 8, 4, 0, 0);

    for (int t = 0; t < 20; t++) begin
      int r, c, n;
      r = $urandom_range(1, 255);
      c = $urandom_range(1, 8);
      n = $urandom_range(0, 24);
      fill_random(c, n);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_job($sformatf("rnd%0d", t), r, c, n, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
